// File: rtl/oled_pkg.sv
// Shared OLED constants, scene identifiers and the scene-mux state type.
// Imported by every file of the pixel path.
package oled_pkg;

  localparam int OLED_W = 96;
  localparam int OLED_H = 64;
  localparam int PI_W   = 13;

  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] YELLOW = 16'hFFE0;

  typedef enum logic [1:0] {
    SCENE_MENU,
    SCENE_MAZE,
    SCENE_WIRE,
    SCENE_COLOUR
  } scene_e;

  typedef enum logic [1:0] {
    ST_SHOW,
    ST_PENDING,
    ST_BLANK
  } mux_state_e;

endpackage

// File: rtl/oled_scene_mux_pixel_coord.sv
// Linear pixel index to column/row conversion for a WIDTH x HEIGHT panel.
// Indices past the last pixel give meaningless coordinates; callers mask them.
module pixel_coord
  import oled_pkg::*;
#(
  parameter int WIDTH  = OLED_W,
  parameter int HEIGHT = OLED_H,
  localparam int PI_W_L = $clog2(WIDTH * HEIGHT),
  localparam int X_W    = $clog2(WIDTH),
  localparam int Y_W    = $clog2(HEIGHT)
) (
  input  logic [PI_W_L-1:0] pixel_index,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y
);

  assign x = X_W'(pixel_index % PI_W_L'(WIDTH));
  assign y = Y_W'(pixel_index / PI_W_L'(WIDTH));

endmodule

// File: rtl/oled_scene_mux.sv
// Arbitrates N_SCENES game pixel streams onto the OLED bus, switching only on
// frame boundaries with optional blank frames, plus a bottom progress bar.
module oled_scene_mux
  import oled_pkg::*;
#(
  parameter int          N_SCENES     = 4,
  parameter int          WIDTH        = OLED_W,
  parameter int          HEIGHT       = OLED_H,
  parameter int          RESET_SCENE  = 0,
  parameter int          BLANK_FRAMES = 2,
  parameter int          BAR_ROWS     = 2,
  parameter logic [15:0] BAR_COLOUR   = YELLOW,
  parameter logic [15:0] BLANK_COLOUR = BLACK,
  localparam int PI_W_L = $clog2(WIDTH * HEIGHT),
  localparam int X_W    = $clog2(WIDTH),
  localparam int Y_W    = $clog2(HEIGHT),
  localparam int SC_W   = $clog2(N_SCENES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_begin,
  input  logic [PI_W_L-1:0]      pixel_index,
  input  logic [16*N_SCENES-1:0] scene_pixel,
  input  logic [SC_W-1:0]        scene_req,
  input  logic                   scene_req_valid,
  output logic                   scene_req_ready,
  input  logic [X_W:0]           bar_len,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [15:0]            pixel_data,
  output logic [SC_W-1:0]        active_scene,
  output logic                   switching,
  output logic                   bad_req,
  output logic [15:0]            frame_count
);

  localparam int BC_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

  mux_state_e      state;
  logic [SC_W-1:0] pending;
  logic [BC_W-1:0] blank_cnt;
  logic [X_W:0]    bar_lim;
  logic            in_range;
  logic            in_bar;

  pixel_coord #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_coord (
    .pixel_index (pixel_index),
    .x           (x),
    .y           (y)
  );

  // The active scene only changes at a frame_begin, so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_SHOW;
      active_scene    <= SC_W'(RESET_SCENE);
      pending         <= '0;
      blank_cnt       <= '0;
      frame_count     <= '0;
      bad_req         <= 1'b0;
      switching       <= 1'b0;
      scene_req_ready <= 1'b1;
    end else begin
      bad_req <= 1'b0;
      if (frame_begin) begin
        frame_count <= frame_count + 16'd1;
      end
      case (state)
        ST_SHOW: begin
          if (scene_req_valid && scene_req_ready) begin
            if (int'(scene_req) >= N_SCENES) begin
              bad_req <= 1'b1;
            end else if (scene_req != active_scene) begin
              pending         <= scene_req;
              state           <= ST_PENDING;
              switching       <= 1'b1;
              scene_req_ready <= 1'b0;
            end
          end
        end
        ST_PENDING: begin
          if (frame_begin) begin
            if (BLANK_FRAMES > 0) begin
              blank_cnt <= BC_W'(BLANK_FRAMES - 1);
              state     <= ST_BLANK;
            end else begin
              active_scene    <= pending;
              state           <= ST_SHOW;
              switching       <= 1'b0;
              scene_req_ready <= 1'b1;
            end
          end
        end
        ST_BLANK: begin
          if (frame_begin) begin
            if (blank_cnt == '0) begin
              active_scene    <= pending;
              state           <= ST_SHOW;
              switching       <= 1'b0;
              scene_req_ready <= 1'b1;
            end else begin
              blank_cnt <= blank_cnt - BC_W'(1);
            end
          end
        end
        default: begin
          state           <= ST_SHOW;
          switching       <= 1'b0;
          scene_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Bar overlay wins over the scene; blank frames and off-panel indices are plain blank.
  always_comb begin
    bar_lim    = (bar_len > (X_W + 1)'(WIDTH)) ? (X_W + 1)'(WIDTH) : bar_len;
    in_range   = int'(pixel_index) < WIDTH * HEIGHT;
    in_bar     = (int'(y) >= HEIGHT - BAR_ROWS) && ({1'b0, x} < bar_lim);
    pixel_data = BLANK_COLOUR;
    if (in_range && state != ST_BLANK) begin
      if (in_bar) begin
        pixel_data = BAR_COLOUR;
      end else begin
        pixel_data = scene_pixel[16 * int'(active_scene) +: 16];
      end
    end
  end

endmodule

// File: tb/tb_oled_scene_mux.sv
// Directed scoreboard bench for oled_scene_mux: coordinates, bar overlay,
// frame-aligned scene switching with blank frames, reset mid-switch, counter wrap.
module tb_oled_scene_mux;
  import oled_pkg::*;

  // Three scenes keep the 2-bit request field able to encode an out-of-range index.
  localparam int N_SC = 3;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              frame_begin;
  logic [12:0]       pixel_index;
  logic [16*N_SC-1:0] scene_pixel;
  logic [1:0]        scene_req;
  logic              scene_req_valid;
  logic              scene_req_ready;
  logic [7:0]        bar_len;
  logic [6:0]        x;
  logic [5:0]        y;
  logic [15:0]       pixel_data;
  logic [1:0]        active_scene;
  logic              switching;
  logic              bad_req;
  logic [15:0]       frame_count;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] scene_col [N_SC] = '{16'h1111, 16'h2222, 16'h3333};
  int          exp_scene = 0;
  bit          exp_blank = 1'b0;

  oled_scene_mux #(
    .N_SCENES     (N_SC),
    .BLANK_FRAMES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_begin     (frame_begin),
    .pixel_index     (pixel_index),
    .scene_pixel     (scene_pixel),
    .scene_req       (scene_req),
    .scene_req_valid (scene_req_valid),
    .scene_req_ready (scene_req_ready),
    .bar_len         (bar_len),
    .x               (x),
    .y               (y),
    .pixel_data      (pixel_data),
    .active_scene    (active_scene),
    .switching       (switching),
    .bad_req         (bad_req),
    .frame_count     (frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] modelPix(input int pi, input int bl);
    int xx, yy, lim;
    if (pi >= 96 * 64 || exp_blank) return 16'h0000;
    xx  = pi % 96;
    yy  = pi / 96;
    lim = (bl > 96) ? 96 : bl;
    if (yy >= 62 && xx < lim) return 16'hFFE0;
    return scene_col[exp_scene];
  endfunction

  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty got=%0h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%0h expected=%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic checkCtl(input string tag, input logic [31:0] obs, input logic [31:0] e);
    sb.push_back('{tag, e});
    checkOutput(obs);
  endtask

  task automatic applyStimulus(input int pi, input int bl, input bit with_xy);
    pixel_index = 13'(pi);
    bar_len     = 8'(bl);
    if (with_xy) begin
      sb.push_back('{$sformatf("x@%0d", pi), 32'(pi % 96)});
      sb.push_back('{$sformatf("y@%0d", pi), 32'(pi / 96)});
    end
    sb.push_back('{$sformatf("pix@%0d/bar%0d", pi, bl), 32'(modelPix(pi, bl))});
    #1;
    if (with_xy) begin
      checkOutput(32'(x));
      checkOutput(32'(y));
    end
    checkOutput(32'(pixel_data));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseFrame();
    frame_begin = 1'b1;
    step();
    frame_begin = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    frame_begin     = 1'b0;
    pixel_index     = '0;
    scene_req       = '0;
    scene_req_valid = 1'b0;
    bar_len         = '0;
    for (int k = 0; k < N_SC; k++) scene_pixel[16*k +: 16] = scene_col[k];
    step();
    step();
    reset = 1'b0;
    checkCtl("rst_ready", 32'(scene_req_ready), 1);
    checkCtl("rst_active", 32'(active_scene), 0);
    checkCtl("rst_switching", 32'(switching), 0);
    checkCtl("rst_bad_req", 32'(bad_req), 0);
    checkCtl("rst_frame_count", 32'(frame_count), 0);

    $display("[TB] coordinates and bar overlay");
    applyStimulus(0, 0, 1);
    applyStimulus(95, 0, 1);
    applyStimulus(96, 0, 1);
    applyStimulus(6143, 0, 1);
    applyStimulus(6144, 0, 0);
    applyStimulus(63*96 + 9, 10, 1);
    applyStimulus(63*96 + 10, 10, 1);
    applyStimulus(61*96 + 9, 10, 1);
    applyStimulus(62*96 + 9, 10, 1);
    applyStimulus(62*96 + 95, 127, 1);
    applyStimulus(61*96 + 95, 127, 1);
    applyStimulus(63*96 + 95, 96, 1);

    $display("[TB] out-of-range and same-scene requests");
    scene_req = 2'd3; scene_req_valid = 1'b1;
    step();
    scene_req_valid = 1'b0;
    checkCtl("bad_req_pulse", 32'(bad_req), 1);
    checkCtl("bad_active", 32'(active_scene), 0);
    checkCtl("bad_switching", 32'(switching), 0);
    step();
    checkCtl("bad_req_drop", 32'(bad_req), 0);
    scene_req = 2'd0; scene_req_valid = 1'b1;
    step();
    scene_req_valid = 1'b0;
    checkCtl("same_switching", 32'(switching), 0);
    checkCtl("same_ready", 32'(scene_req_ready), 1);

    $display("[TB] switch to scene 2 with two blank frames");
    scene_req = 2'd2; scene_req_valid = 1'b1;
    step();
    scene_req_valid = 1'b0;
    checkCtl("pend_ready", 32'(scene_req_ready), 0);
    checkCtl("pend_switching", 32'(switching), 1);
    repeat (3) step();
    applyStimulus(0, 0, 0);
    applyStimulus(62*96 + 3, 127, 0);
    pulseFrame();
    exp_blank = 1'b1;
    applyStimulus(0, 0, 0);
    applyStimulus(62*96 + 3, 127, 0);
    checkCtl("blank1_active", 32'(active_scene), 0);
    repeat (2) step();
    pulseFrame();
    applyStimulus(5, 0, 0);
    checkCtl("blank2_switching", 32'(switching), 1);
    pulseFrame();
    exp_blank = 1'b0;
    exp_scene = 2;
    checkCtl("sw_active", 32'(active_scene), 2);
    checkCtl("sw_switching", 32'(switching), 0);
    checkCtl("sw_ready", 32'(scene_req_ready), 1);
    checkCtl("sw_frame_count", 32'(frame_count), 3);
    applyStimulus(0, 0, 0);

    $display("[TB] request coincident with frame_begin");
    scene_req = 2'd1; scene_req_valid = 1'b1; frame_begin = 1'b1;
    step();
    scene_req_valid = 1'b0; frame_begin = 1'b0;
    checkCtl("coin_switching", 32'(switching), 1);
    checkCtl("coin_frame_count", 32'(frame_count), 4);
    applyStimulus(0, 0, 0);
    pulseFrame();
    exp_blank = 1'b1;
    applyStimulus(0, 0, 0);
    checkCtl("coin_active", 32'(active_scene), 2);

    $display("[TB] reset during blank");
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_blank = 1'b0;
    exp_scene = 0;
    checkCtl("mid_rst_switching", 32'(switching), 0);
    checkCtl("mid_rst_active", 32'(active_scene), 0);
    checkCtl("mid_rst_ready", 32'(scene_req_ready), 1);
    repeat (3) pulseFrame();
    checkCtl("pending_lost", 32'(active_scene), 0);
    applyStimulus(0, 0, 0);

    $display("[TB] frame counter wrap");
    reset = 1'b1;
    step();
    reset = 1'b0;
    frame_begin = 1'b1;
    repeat (65535) step();
    frame_begin = 1'b0;
    checkCtl("fc_ffff", 32'(frame_count), 32'hFFFF);
    repeat (2) pulseFrame();
    checkCtl("fc_wrap", 32'(frame_count), 1);
    checkCtl("fc_switching", 32'(switching), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
